fifo_parametrizado: RTL
=======================

FIFO_PARAMETRIZADO -- requirements
Module: fifo_parametrizado

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, pointer width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port FIFO_data_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port push  input  1  write request.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port FIFO_data_out  output  DATA_WIDTH  registered read data.
REQ-011 SHALL have port valid_out  output  1  FIFO_data_out holds a newly popped word.
REQ-012 SHALL have port full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-013 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.
REQ-014 SHALL have port fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL keep internal wr_ptr and rd_ptr, ADDR_WIDTH bits each, wrapping DEPTH-1 -> 0 without extra logic.
REQ-017 SHALL store DEPTH x DATA_WIDTH words; storage is not cleared by reset.
REQ-018 SHALL accept push when not full: write FIFO_data_in at wr_ptr, wr_ptr+1, count+1.
REQ-019 SHALL accept pop when not empty: read word at rd_ptr into FIFO_data_out, rd_ptr+1, count-1.
REQ-020 SHALL present popped data one cycle after the accepting edge; valid_out high exactly that cycle.
REQ-021 SHALL hold FIFO_data_out at its last value when no pop is accepted; valid_out low.
REQ-022 SHALL, on push+pop while 0 < count < DEPTH, accept both; count unchanged.
REQ-023 SHALL, on push+pop while full, accept both (pop frees a slot); overflow not set.
REQ-024 SHALL, on push+pop while empty, accept push only, ignore pop, set underflow.
REQ-025 SHALL ignore push while full (no pointer/memory change) and set overflow.
REQ-026 SHALL ignore pop while empty and set underflow.
REQ-027 SHALL hold overflow/underflow high once set, until reset.
REQ-028 SHALL derive full, empty, almost_full, almost_empty combinationally from registered fifo_count.
REQ-029 SHALL never let fifo_count exceed DEPTH or drop below 0.

Reset
REQ-030 SHALL, on reset high, immediately (no clock) clear wr_ptr, rd_ptr, fifo_count, FIFO_data_out, valid_out, overflow, underflow.
REQ-031 SHALL, during reset, output empty=1, almost_empty=1, full=0, almost_full=0.
REQ-032 SHALL discard in-flight push/pop when reset asserts mid-operation; first accepted op after release uses pointer 0.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, ALMOST_FULL_TH=3, ALMOST_EMPTY_TH=1)
REQ-033 SHALL pass: push 8'hFF, 8'hAF, 8'h17 then pop x3 -> FIFO_data_out FF, AF, 17 each one cycle after pop, valid_out pulses; empty=1 at end.
REQ-034 SHALL pass: push 5 words 8'hB8,8'h6A,8'h01,8'h05,8'h8A -> full=1 after 4th, 5th ignored, overflow=1, count=4; pops return B8,6A,01,05.
REQ-035 SHALL pass: pop on empty -> underflow=1, count=0, valid_out=0, FIFO_data_out unchanged; underflow still 1 ten cycles later.
REQ-036 SHALL pass: with count=4, push 8'h5C + pop same cycle -> count stays 4, overflow=0, popped oldest word; 8'h5C read last.
REQ-037 SHALL pass: 10 push/pop pairs forcing pointer wrap -> data order preserved, count tracks; almost_full at 3, almost_empty at <=1.
REQ-038 SHALL pass: reset asserted between clock edges with count=3 -> all outputs at reset values before next edge; push 8'h76 after release reads back 8'h76.

Source files
------------

// File: rtl/fifo_parametrizado.sv
// Synchronous single-clock FIFO with occupancy count, threshold flags and
// sticky overflow/underflow error indicators.
module fifo_parametrizado #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] FIFO_data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] FIFO_data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Status flags decoded from the registered occupancy count
    always_comb begin
        full         = (fifo_count == CW'(DEPTH));
        empty        = (fifo_count == '0);
        almost_full  = (fifo_count >= CW'(ALMOST_FULL_TH));
        almost_empty = (fifo_count <= CW'(ALMOST_EMPTY_TH));
    end

    // Acceptance: a pop on a full FIFO frees the slot the same-cycle push uses
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop);
    end

    // Storage array; deliberately not cleared on reset
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= FIFO_data_in;
        end
    end

    // Pointers, occupancy, read register and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            FIFO_data_out <= '0;
            valid_out     <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr        <= rd_ptr + ADDR_WIDTH'(1);
                FIFO_data_out <= mem[rd_ptr];
            end
            valid_out <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
